// File: rtl/addersub_pipe_pkg.sv
// Shared op encodings and op-field bit positions for the pipelined adder/subtractor.
package addersub_pipe_pkg;

  // op = {is_slt, signext, addsub}
  localparam int OP_ADDSUB_BIT  = 0;
  localparam int OP_SIGNEXT_BIT = 1;
  localparam int OP_SLT_BIT     = 2;

  localparam logic [2:0] OP_SUBU = 3'b000;
  localparam logic [2:0] OP_ADDU = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SLTU = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b110;

  // Only signed add/subtract can report a signed overflow.
  function automatic logic op_is_signed_arith(input logic [2:0] o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/addersub_seg.sv
// One carry segment of the split adder: a + (addsub ? b : ~b) + cin.
module addersub_seg #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         addsub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] b_eff;

  assign b_eff       = addsub ? b : ~b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, cin};

endmodule

// File: rtl/addersub_pipe.sv
// Multi-lane pipelined add/subtract/set-less-than unit with valid/ready handshake.
// The (WIDTH+1)-bit extended adder is cut into STAGES carry segments; segment k
// is evaluated while loading stage k, and the carry between segments is registered.
// Optional signed-overflow output: define ADDERSUB_PIPE_OVERFLOW_EN.
module addersub_pipe
  import addersub_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 1,
  parameter int STAGES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic [LANES*WIDTH-1:0] opA,
  input  logic [LANES*WIDTH-1:0] opB,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       result_slt
`ifdef ADDERSUB_PIPE_OVERFLOW_EN
  ,
  output logic [LANES-1:0]       overflow
`endif
);

  localparam int EW  = WIDTH + 1;
  localparam int SEG = WIDTH / STAGES;

  // Stage registers; sum_q[k] holds valid bits only up to the end of segment k,
  // everything above stays zero so the next segment can simply be OR-ed in.
  logic [STAGES-1:0]                    valid;
  logic [STAGES-1:0][2:0]               op_q;
  logic [STAGES-1:0][LANES-1:0][EW-1:0] a_q, b_q, sum_q;
  logic [STAGES-1:0][LANES-1:0]         c_q;

  // What each stage would load: inputs for stage 0, previous stage otherwise.
  logic [STAGES-1:0]                    src_vld;
  logic [STAGES-1:0][2:0]               src_op;
  logic [STAGES-1:0][LANES-1:0][EW-1:0] src_a, src_b, src_sum, nxt_sum;
  logic [STAGES-1:0][LANES-1:0]         src_c, nxt_c;

  logic [STAGES-1:0] load;

  // Bubble collapse: a stage may load if it or any stage downstream is empty,
  // or the output is being taken this cycle.
  always_comb begin
    logic ld;
    ld   = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld      = ld || !valid[k];
      load[k] = ld;
    end
  end

  assign in_ready = !reset && load[0];

  assign src_vld[0] = in_valid && in_ready;
  assign src_op[0]  = op;

  for (genvar l = 0; l < LANES; l++) begin : g_in
    assign src_a[0][l]   = {op[OP_SIGNEXT_BIT] & opA[l*WIDTH+WIDTH-1], opA[l*WIDTH +: WIDTH]};
    assign src_b[0][l]   = {op[OP_SIGNEXT_BIT] & opB[l*WIDTH+WIDTH-1], opB[l*WIDTH +: WIDTH]};
    assign src_sum[0][l] = '0;
    // Subtraction is a + ~b + 1, so the first carry-in is the inverse of addsub.
    assign src_c[0][l]   = ~op[OP_ADDSUB_BIT];
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_fwd
    assign src_vld[k] = valid[k-1];
    assign src_op[k]  = op_q[k-1];
    assign src_a[k]   = a_q[k-1];
    assign src_b[k]   = b_q[k-1];
    assign src_sum[k] = sum_q[k-1];
    assign src_c[k]   = c_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int SW = (k == STAGES - 1) ? SEG + 1 : SEG;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [SW-1:0] seg_s;
      logic [EW-1:0] seg_ext;
      addersub_seg #(.N(SW)) u_seg (
        .a      (src_a[k][l][LO +: SW]),
        .b      (src_b[k][l][LO +: SW]),
        .cin    (src_c[k][l]),
        .addsub (src_op[k][OP_ADDSUB_BIT]),
        .sum    (seg_s),
        .cout   (nxt_c[k][l])
      );
      assign seg_ext        = EW'(seg_s);
      assign nxt_sum[k][l]  = src_sum[k][l] | (seg_ext << LO);
    end
  end

  // Stage registers: valid follows the handshake, data only moves with a valid op.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid[k] <= src_vld[k];
          if (src_vld[k]) begin
            op_q[k]  <= src_op[k];
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            sum_q[k] <= nxt_sum[k];
            c_q[k]   <= nxt_c[k];
          end
        end
      end
    end
  end

  assign out_valid = valid[STAGES-1];

  for (genvar l = 0; l < LANES; l++) begin : g_out
    assign result[l*WIDTH +: WIDTH] = sum_q[STAGES-1][l][WIDTH-1:0];
    assign result_slt[l]            = sum_q[STAGES-1][l][WIDTH];
`ifdef ADDERSUB_PIPE_OVERFLOW_EN
    // Sign-extended operands make the WIDTH+1 result exact; a mismatch between
    // its top two bits means the WIDTH-bit signed result wrapped.
    assign overflow[l] = op_is_signed_arith(op_q[STAGES-1]) &&
                         (sum_q[STAGES-1][l][WIDTH] ^ sum_q[STAGES-1][l][WIDTH-1]);
`endif
  end

  // Operands and final carry of the last stage have no consumer.
  logic unused_ok;
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1], op_q[STAGES-1]};

endmodule

// File: tb/tb_addersub_pipe.sv
// Scoreboard bench: instance 0 (STAGES=2) takes directed vectors, instances 1 and 2
// (STAGES=1 and STAGES=4) take random ops under random out_ready.
`timescale 1ns/1ps
module tb_addersub_pipe;
  import addersub_pipe_pkg::*;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int NI = 3;

  typedef struct packed {
    logic [L*W-1:0] res;
    logic [L-1:0]   slt;
    logic [L-1:0]   ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NI-1:0]               iv, irdy, ovld, ordy;
  logic [NI-1:0][2:0]          op_s;
  logic [NI-1:0][L*W-1:0]      a_s, b_s, res;
  logic [NI-1:0][L-1:0]        slt, ovf;

  exp_t exp_q[NI][$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   bp_done  = 1'b0;
  bit   rdone    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    addersub_pipe #(.WIDTH(W), .LANES(L), .STAGES(ST)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (iv[g]),
      .in_ready   (irdy[g]),
      .op         (op_s[g]),
      .opA        (a_s[g]),
      .opB        (b_s[g]),
      .out_valid  (ovld[g]),
      .out_ready  (ordy[g]),
      .result     (res[g]),
      .result_slt (slt[g])
`ifdef ADDERSUB_PIPE_OVERFLOW_EN
      ,
      .overflow   (ovf[g])
`endif
    );
`ifndef ADDERSUB_PIPE_OVERFLOW_EN
    assign ovf[g] = '0;
`endif

    // Monitor: compare the presented output against the queue head every cycle it
    // is valid (so held outputs are checked too); pop on handshake.
    bit hold_v = 1'b0;
    always @(negedge clk) begin
      exp_t e;
      #2;
      if (reset !== 1'b0) hold_v = 1'b0;
      else begin
        if (hold_v) check($sformatf("dut%0d_hold_out_valid", g), ovld[g], 1);
        if (ovld[g] === 1'b1) begin
          check($sformatf("dut%0d_output_expected", g), exp_q[g].size() != 0, 1);
          if (exp_q[g].size() != 0) begin
            e = exp_q[g][0];
            check($sformatf("dut%0d_result", g), res[g], e.res);
            check($sformatf("dut%0d_result_slt", g), slt[g], e.slt);
`ifdef ADDERSUB_PIPE_OVERFLOW_EN
            check($sformatf("dut%0d_overflow", g), ovf[g], e.ovf);
`endif
            if (ordy[g]) void'(exp_q[g].pop_front());
          end
        end
        hold_v = (ovld[g] === 1'b1) && !ordy[g];
      end
    end
  end

  // Independent reference: plain extended arithmetic plus a wide signed range test.
  function automatic exp_t model(input logic [2:0] o, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    exp_t e;
    e = '0;
    for (int l = 0; l < L; l++) begin
      logic [W:0] ea, eb, s;
      longint sa, sb, t;
      ea = {o[1] & a[l*W+W-1], a[l*W +: W]};
      eb = {o[1] & b[l*W+W-1], b[l*W +: W]};
      s  = o[0] ? ea + eb : ea - eb;
      e.res[l*W +: W] = s[W-1:0];
      e.slt[l]        = s[W];
      sa = longint'($signed(a[l*W +: W]));
      sb = longint'($signed(b[l*W +: W]));
      t  = o[0] ? sa + sb : sa - sb;
      e.ovf[l] = ((o == OP_ADD) || (o == OP_SUB)) &&
                 ((t > 64'sh7FFFFFFF) || (t < -64'sh80000000));
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int g, input logic [2:0] o, input logic [L*W-1:0] a,
                      input logic [L*W-1:0] b, input exp_t e);
    int n = 0;
    exp_q[g].push_back(e);
    iv[g] = 1'b1; op_s[g] = o; a_s[g] = a; b_s[g] = b;
    #1;
    while (irdy[g] !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      check($sformatf("dut%0d_accept_timeout", g), irdy[g], 1);
      iv[g] = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      iv[g] = 1'b0;
    end
  endtask

  task automatic vec(input logic [2:0] o, input logic [31:0] a1, a0, b1, b0, r1, r0,
                     input logic [1:0] s, input logic [1:0] v);
    exp_t e;
    e.res = {r1, r0}; e.slt = s; e.ovf = v;
    send(0, o, {a1, a0}, {b1, b0}, e);
  endtask

  task automatic wait_empty(input int g);
    int n = 0;
    while (exp_q[g].size() != 0 && n < 500) begin @(negedge clk); n++; end
    check($sformatf("dut%0d_drained", g), exp_q[g].size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] rand_op();
    case ($urandom_range(0, 5))
      0: return OP_SUBU;
      1: return OP_SUB;
      2: return OP_ADDU;
      3: return OP_ADD;
      4: return OP_SLTU;
      default: return OP_SLT;
    endcase
  endfunction

  task automatic rand_run(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      logic [2:0]     o;
      logic [L*W-1:0] a, b;
      o = rand_op();
      a = {pick(), pick()};
      b = {pick(), pick()};
      send(g, o, a, b, model(o, a, b));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iv = '0; ordy = '0; op_s = '0; a_s = '0; b_s = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check("reset_out_valid", ovld[0], 0);
    check("reset_in_ready", irdy[0], 1);
    check("reset_result", res[0], 0);
    check("reset_result_slt", slt[0], 0);
    ordy = '1;
    @(negedge clk);

    // Latency: out_valid absent one cycle after accept, present the next.
    vec(OP_SUBU, 32'd10, 32'd5, 32'd3, 32'd7, 32'd7, 32'hFFFFFFFE, 2'b01, 2'b00);
    #3 check("latency_cycle1_out_valid", ovld[0], 0);
    @(negedge clk);
    #3 check("latency_cycle2_out_valid", ovld[0], 1);
    @(negedge clk);

    // Back-to-back directed vectors.
    vec(OP_SLTU, 32'd7, 32'd5, 32'd5, 32'd7, 32'd2, 32'hFFFFFFFE, 2'b01, 2'b00);
    vec(OP_SLT,  32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd2, 32'hFFFFFFFE, 2'b01, 2'b00);
    vec(OP_SLTU, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd2, 32'hFFFFFFFE, 2'b10, 2'b00);
    vec(OP_ADD,  32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd1, 32'd0, 32'h80000000, 2'b00, 2'b01);
    vec(OP_ADDU, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd1, 32'd0, 32'h80000000, 2'b10, 2'b00);
    vec(OP_SUB,  32'd0, 32'h80000000, 32'd0, 32'd1, 32'd0, 32'h7FFFFFFF, 2'b01, 2'b01);
    vec(OP_SUB,  32'hFFFFFFFE, 32'd5, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 2'b11, 2'b00);
    wait_empty(0);

    // Backpressure: out_ready low for 5 cycles while 4 ops are offered.
    @(negedge clk);
    ordy[0] = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) begin
          exp_t e;
          e.res = {32'(101 + k), 32'(11 * k)}; e.slt = 2'b00; e.ovf = 2'b00;
          send(0, OP_ADDU, {32'(100 + k), 32'(k)}, {32'd1, 32'(10 * k)}, e);
        end
        bp_done = 1'b1;
      end
    join_none
    @(negedge clk);
    @(negedge clk);
    #3;
    check("bp_in_ready_full", irdy[0], 0);
    check("bp_out_valid_full", ovld[0], 1);
    repeat (3) begin
      @(negedge clk);
      #3 check("bp_in_ready_held", irdy[0], 0);
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    begin
      int n = 0;
      while (!bp_done && n < 100) begin @(negedge clk); n++; end
      check("bp_sender_done", bp_done, 1);
    end
    wait_empty(0);

    // Reset with two ops in flight, junk offered during reset.
    @(negedge clk);
    ordy[0] = 1'b0;
    vec(OP_ADDU, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 2'b00, 2'b00);
    vec(OP_ADDU, 32'd2, 32'd2, 32'd2, 32'd2, 32'd4, 32'd4, 2'b00, 2'b00);
    reset = 1'b1;
    exp_q[0].delete();
    iv[0] = 1'b1; op_s[0] = OP_ADD; a_s[0] = {32'd9, 32'd9}; b_s[0] = {32'd9, 32'd9};
    @(negedge clk);
    #3 check("rst_out_valid", ovld[0], 0);
    check("rst_result_cleared", res[0], 0);
    reset = 1'b0;
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    #3 check("rst_release_in_ready", irdy[0], 1);
    repeat (3) begin
      @(negedge clk);
      #3 check("rst_no_stale_out_valid", ovld[0], 0);
    end

    // Random ops on the STAGES=1 and STAGES=4 instances.
    @(negedge clk);
    fork
      begin
        fork
          rand_run(1, 1000);
          rand_run(2, 1000);
        join
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(negedge clk);
          ordy[1] = ($urandom_range(0, 3) != 0);
          ordy[2] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ordy = '1;
    wait_empty(1);
    wait_empty(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addersub_pipe.md
ADDERSUB_PIPE -- requirements
Module: addersub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width per lane, multiple of STAGES.
REQ-002 SHALL have parameter LANES, default 1: independent lanes sharing one op and one handshake.
REQ-003 SHALL have parameter STAGES, default 1: pipeline depth (1..4); adder split into STAGES carry segments.
REQ-004 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: operands and op valid this cycle.
REQ-007 SHALL have port in_ready  output  1: block accepts when in_valid and in_ready both high.
REQ-008 SHALL have port op  input  3: {is_slt, signext, addsub}; 000 SUBU, 010 SUB, 001 ADDU, 011 ADD, 100 SLTU, 110 SLT; other codes undefined.
REQ-009 SHALL have port opA  input  LANES*WIDTH: lane i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port opB  input  LANES*WIDTH: packed as opA.
REQ-011 SHALL have port out_valid  output  1: result presented.
REQ-012 SHALL have port out_ready  input  1: consumer takes result when out_valid and out_ready both high.
REQ-013 SHALL have port result  output  LANES*WIDTH: per-lane sum/difference bits [WIDTH-1:0].
REQ-014 SHALL have port result_slt  output  LANES: per-lane bit WIDTH of the (WIDTH+1)-bit extended result.
REQ-015 SHALL have port overflow  output  LANES: per-lane signed overflow (present only under REQ-031).

Function
REQ-016 SHALL per lane compute {signext&A[msb],A} +/- {signext&B[msb],B} in WIDTH+1 bits: addsub=1 adds, addsub=0 subtracts (two's complement, carry-in 1).
REQ-017 SHALL split the WIDTH+1 adder into STAGES segments of WIDTH/STAGES bits, last segment also holding bit WIDTH; segment k computed in stage k; inter-segment carry registered.
REQ-018 SHALL carry unprocessed operand bits and op forward with each stage; no combinational path from opA/opB to result when STAGES>1.
REQ-019 SHALL have latency exactly STAGES cycles from accept to out_valid with no backpressure; throughput one op per cycle.
REQ-020 SHALL give each stage a valid bit; stage k loads when stage k+1 is empty or advancing this cycle (bubble collapse); last stage advances on out_ready.
REQ-021 SHALL drive in_ready = !valid[0] || stage-0 advancing; in_ready may depend combinationally on out_ready.
REQ-022 SHALL hold result, result_slt, overflow and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL preserve issue order; no op dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 SHALL accept a new op in the same cycle the last stage drains when pipeline full.
REQ-025 SHALL ignore opA/opB/op when in_valid low or in_ready low.
REQ-026 SHALL, with STAGES=1, behave as a single registered stage (latency 1).

Reset
REQ-027 SHALL clear all stage valid bits on reset, giving out_valid=0 the following cycle.
REQ-028 SHALL reset result, result_slt and overflow registers to 0.
REQ-029 SHALL discard all in-flight ops on reset, including mid-pipeline; in_ready=1 the cycle after reset deasserts.
REQ-030 SHALL not accept input in a cycle where reset is high.

Configuration
REQ-031 SHALL implement the overflow port and logic only when macro ADDERSUB_PIPE_OVERFLOW_EN is defined: overflow[i]=1 iff op is ADD or SUB and the WIDTH-bit signed result differs from the true result; 0 for unsigned and SLT ops.
REQ-032 SHALL omit the overflow port and its registers when ADDERSUB_PIPE_OVERFLOW_EN is undefined; all other behaviour unchanged.

Structure
REQ-033 SHALL place op encodings (OP_SUBU..OP_SLT) and the op-field bit indices in the shared scalar options package/include.
REQ-034 SHALL use one sub-module addersub_seg: one segment adder, inputs a, b, cin, addsub, outputs sum, cout, instantiated per lane per stage.

Verification (WIDTH=32, LANES=2, STAGES=2 unless stated)
REQ-035 SHALL check SUBU 5-7 -> result 0xFFFFFFFE, out_valid exactly 2 cycles after accept; SLTU 5,7 -> result_slt=1.
REQ-036 SHALL check SLT A=0xFFFFFFFF, B=1 -> result_slt=1; SLTU same operands -> result_slt=0, lanes independent with differing data.
REQ-037 SHALL check with macro defined: ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1; ADDU same -> overflow=0.
REQ-038 SHALL check out_ready low 5 cycles while in_valid held with 4 ops -> in_ready drops after 2 accepts, outputs stable, then 4 results in order, none lost.
REQ-039 SHALL check reset asserted with 2 ops in flight -> out_valid=0 next cycle, no stale result after reset release.
REQ-040 SHALL check STAGES=1 and STAGES=4 with 1000 random ops at random out_ready against a reference model.
